// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin arbiter that frames one requester's payload
// with preamble/SFD header bytes and a fixed idle gap before re-arbitrating.
// Optional feature macro: TX_ARB_MAXLEN_EN (truncate payload at MAX_PAYLOAD bytes).
module tx_frame_arbiter #(
    parameter int unsigned   NREQ          = 2,
    parameter int unsigned   D             = 8,
    parameter int unsigned   PREAMBLE_LEN  = 2,
    parameter logic [D-1:0]  PREAMBLE_BYTE = D'(8'h55),
    parameter logic [D-1:0]  SFD_BYTE      = D'(8'hD5),
    parameter int unsigned   GAP_CYCLES    = 4,
    parameter int unsigned   MAX_PAYLOAD   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*D-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              frame_abort,
    output logic              frame_trunc,
    input  logic              tx_rdy,
    output logic              tx_send,
    output logic [D-1:0]      tx_data
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = 8;
`ifdef TX_ARB_MAXLEN_EN
    localparam int unsigned PW = $clog2(MAX_PAYLOAD + 1);
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        PAYLOAD  = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   gidx, gidx_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
`ifdef TX_ARB_MAXLEN_EN
    logic [PW-1:0]   pcnt, pcnt_nxt;
`else
    logic            unused_maxlen;
    assign unused_maxlen = (MAX_PAYLOAD == 0);
`endif

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic            req_g;
    logic            last_g;
    logic [D-1:0]    data_g;

    // Round-robin pick: lowest offset from ptr with req high wins
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((32'(ptr) + 32'(k)) % NREQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign req_g  = req[gidx];
    assign last_g = req_last[gidx];
    assign data_g = req_data[32'(gidx) * D +: D];
    assign busy   = (state != IDLE);

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gidx  <= '0;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
`ifdef TX_ARB_MAXLEN_EN
            pcnt  <= '0;
`endif
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
`ifdef TX_ARB_MAXLEN_EN
            pcnt  <= pcnt_nxt;
`endif
        end
    end

    // Next-state logic and per-state transmitter/handshake outputs
    always_comb begin
        state_nxt   = state;
        gidx_nxt    = gidx;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
`ifdef TX_ARB_MAXLEN_EN
        pcnt_nxt    = pcnt;
`endif
        tx_send     = 1'b0;
        tx_data     = '0;
        req_ack     = '0;
        frame_abort = 1'b0;
        frame_trunc = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    gidx_nxt  = pick_idx;
                    grant_nxt = NREQ'(1'b1) << pick_idx;
                    ptr_nxt   = IW'((32'(pick_idx) + 32'd1) % NREQ);
                    cnt_nxt   = '0;
`ifdef TX_ARB_MAXLEN_EN
                    pcnt_nxt  = '0;
`endif
                    state_nxt = PREAMBLE;
                end
            end

            PREAMBLE: begin
                tx_send = 1'b1;
                tx_data = PREAMBLE_BYTE;
                if (tx_rdy) begin
                    if (cnt == CW'(PREAMBLE_LEN - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = SFD;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end

            SFD: begin
                tx_send = 1'b1;
                tx_data = SFD_BYTE;
                if (tx_rdy) begin
                    state_nxt = PAYLOAD;
                end
            end

            PAYLOAD: begin
                if (!req_g) begin
                    // Owner withdrew mid-frame: close the frame without an ack
                    frame_abort = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = GAP;
                end else begin
                    tx_send = 1'b1;
                    tx_data = data_g;
                    if (tx_rdy) begin
                        req_ack[gidx] = 1'b1;
                        if (last_g) begin
                            cnt_nxt   = '0;
                            state_nxt = GAP;
                        end
`ifdef TX_ARB_MAXLEN_EN
                        else if (pcnt == PW'(MAX_PAYLOAD - 1)) begin
                            frame_trunc = 1'b1;
                            cnt_nxt     = '0;
                            state_nxt   = GAP;
                        end else begin
                            pcnt_nxt = pcnt + PW'(1);
                        end
`endif
                    end
                end
            end

            GAP: begin
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter (NREQ=2, D=8, default header/gap).
module tb_tx_frame_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ack;
    logic [1:0]  grant;
    logic        busy;
    logic        frame_abort;
    logic        frame_trunc;
    logic        tx_rdy;
    logic        tx_send;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;

    tx_frame_arbiter #(
        .NREQ        (2),
        .D           (8),
        .PREAMBLE_LEN(2),
        .GAP_CYCLES  (4),
        .MAX_PAYLOAD (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ack    (req_ack),
        .grant      (grant),
        .busy       (busy),
        .frame_abort(frame_abort),
        .frame_trunc(frame_trunc),
        .tx_rdy     (tx_rdy),
        .tx_send    (tx_send),
        .tx_data    (tx_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; samples at the following negedge, returns at next posedge+1
    task automatic cyc(input string tag, input logic s, input logic [7:0] d,
                       input logic [1:0] a, input logic [1:0] g, input logic b,
                       input logic ab, input logic tr);
        @(negedge clk);
        check({tag, " tx_send"}, 32'(tx_send), 32'(s));
        check({tag, " tx_data"}, 32'(tx_data), 32'(d));
        check({tag, " req_ack"}, 32'(req_ack), 32'(a));
        check({tag, " grant"}, 32'(grant), 32'(g));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " frame_abort"}, 32'(frame_abort), 32'(ab));
        check({tag, " frame_trunc"}, 32'(frame_trunc), 32'(tr));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        req_last = '0;
        req_data = '0;
        tx_rdy   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        req_last = '0;
        tx_rdy   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        cyc("rst", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);

        // Three-byte frame from requester 0
        do_reset();
        req = 2'b01; req_data = 16'h00B0; req_last = 2'b00; tx_rdy = 1'b1;
        cyc("f1 idle", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);
        cyc("f1 pre0", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("f1 pre1", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("f1 sfd",  1, 8'hD5, 2'b00, 2'b01, 1, 0, 0);
        cyc("f1 b0",   1, 8'hB0, 2'b01, 2'b01, 1, 0, 0);
        req_data = 16'h00B1;
        cyc("f1 b1",   1, 8'hB1, 2'b01, 2'b01, 1, 0, 0);
        req_data = 16'h00B2; req_last = 2'b01;
        cyc("f1 b2",   1, 8'hB2, 2'b01, 2'b01, 1, 0, 0);
        req = 2'b00; req_last = 2'b00; req_data = '0;
        for (int i = 0; i < 4; i++) cyc("f1 gap", 0, 8'h00, 2'b00, 2'b01, 1, 0, 0);
        cyc("f1 done", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);

        // Both requesting: one-byte frames alternate, gap+idle between frames
        do_reset();
        req = 2'b11; req_last = 2'b11; req_data = 16'hA1A0;
        for (int f = 0; f < 4; f++) begin
            logic [1:0] g;
            logic [7:0] pd;
            g  = (f % 2 == 0) ? 2'b01 : 2'b10;
            pd = (f % 2 == 0) ? 8'hA0 : 8'hA1;
            cyc("rr idle", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);
            cyc("rr pre0", 1, 8'h55, 2'b00, g, 1, 0, 0);
            cyc("rr pre1", 1, 8'h55, 2'b00, g, 1, 0, 0);
            cyc("rr sfd",  1, 8'hD5, 2'b00, g, 1, 0, 0);
            cyc("rr pay",  1, pd,    g,     g, 1, 0, 0);
            for (int i = 0; i < 4; i++) cyc("rr gap", 0, 8'h00, 2'b00, g, 1, 0, 0);
        end

        // Stall in SFD: byte held, single transfer
        do_reset();
        req = 2'b01; req_data = 16'h00C0; req_last = 2'b01; tx_rdy = 1'b1;
        cyc("st idle", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);
        cyc("st pre0", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("st pre1", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        tx_rdy = 1'b0;
        cyc("st sfd w0", 1, 8'hD5, 2'b00, 2'b01, 1, 0, 0);
        cyc("st sfd w1", 1, 8'hD5, 2'b00, 2'b01, 1, 0, 0);
        tx_rdy = 1'b1;
        cyc("st sfd go", 1, 8'hD5, 2'b00, 2'b01, 1, 0, 0);
        cyc("st pay",    1, 8'hC0, 2'b01, 2'b01, 1, 0, 0);
        req = 2'b00; req_last = 2'b00;
        cyc("st gap0",   0, 8'h00, 2'b00, 2'b01, 1, 0, 0);

        // Abort: owner drops req after one payload byte
        do_reset();
        req = 2'b01; req_data = 16'h00E0; req_last = 2'b00; tx_rdy = 1'b1;
        cyc("ab idle", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);
        cyc("ab pre0", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("ab pre1", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("ab sfd",  1, 8'hD5, 2'b00, 2'b01, 1, 0, 0);
        cyc("ab b0",   1, 8'hE0, 2'b01, 2'b01, 1, 0, 0);
        req = 2'b10; req_data = 16'h33E1;
        cyc("ab drop", 0, 8'h00, 2'b00, 2'b01, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc("ab gap", 0, 8'h00, 2'b00, 2'b01, 1, 0, 0);
        req = 2'b00;
        cyc("ab done", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);

        // Reset while in PAYLOAD
        do_reset();
        req = 2'b01; req_data = 16'h00F0; req_last = 2'b00; tx_rdy = 1'b1;
        cyc("mr idle", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);
        cyc("mr pre0", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("mr pre1", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("mr sfd",  1, 8'hD5, 2'b00, 2'b01, 1, 0, 0);
        cyc("mr b0",   1, 8'hF0, 2'b01, 2'b01, 1, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("mr after", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);

`ifdef TX_ARB_MAXLEN_EN
        // Six-byte frame truncated after four payload bytes
        do_reset();
        req = 2'b01; req_data = 16'h00D0; req_last = 2'b00; tx_rdy = 1'b1;
        cyc("tr idle", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);
        cyc("tr pre0", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("tr pre1", 1, 8'h55, 2'b00, 2'b01, 1, 0, 0);
        cyc("tr sfd",  1, 8'hD5, 2'b00, 2'b01, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] pd;
            pd = 8'hD0 + 8'(i);
            req_data = {8'h00, pd};
            cyc("tr pay", 1, pd, 2'b01, 2'b01, 1, 0, (i == 3));
        end
        req_data = 16'h00D4;
        cyc("tr gap0", 0, 8'h00, 2'b00, 2'b01, 1, 0, 0);
        req = 2'b00;
        for (int i = 0; i < 3; i++) cyc("tr gap", 0, 8'h00, 2'b00, 2'b01, 1, 0, 0);
        cyc("tr done", 0, 8'h00, 2'b00, 2'b00, 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
